vram_ctrl: RTL and testbench
============================

# vram_ctrl

Write scheduler and clear sequencer for the tile-video picture memories: palette definitions, tile bitmaps, per-cell palette map and per-cell tile map. It accepts CPU writes through a small FIFO and range-checks each one. Accepted writes are committed to a single shared memory write port only during display blanking, so the pixel pipeline never sees a mid-line change. It also replaces the one-cycle bulk clear with a sequenced walk that zeroes every memory.

## Interface
- DEPTH, 4, write FIFO entries (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- blank  in  1  high while the video timing is outside the active area (hblank or vblank)
- cpu_wr  in  1  write request, qualified by cpu_ready
- cpu_sel  in  2  target: 0 paldef, 1 tiledef, 2 palmap, 3 tilemap
- cpu_addr  in  10  word address (tiledef: {tile[5:0], word[3:0]})
- cpu_data  in  16  write data; low 12/16/8/6 bits used per target
- cpu_ready  out  1  FIFO can accept this cycle
- clear_req  in  1  pulse: start a full clear
- busy  out  1  clear in progress
- cpu_err  out  1  sticky: an out-of-range write was dropped
- mem_we  out  1  memory write strobe, registered
- mem_sel  out  2  memory select, registered
- mem_addr  out  10  memory address, registered
- mem_data  out  16  write data, registered, unused upper bits zero

## Operation
- Valid ranges:
  - paldef: addr < 16.
  - tiledef: addr < 1024.
  - palmap and tilemap: addr < 300.
- Handshake: a write is accepted on any edge where cpu_wr && cpu_ready.
  - An in-range accepted write is pushed to the FIFO.
  - An out-of-range accepted write is consumed, not queued, and sets cpu_err.
- cpu_ready = !full && state==IDLE. It is combinational from registered state.
- A push when full is impossible. A pop does not free a slot within the same cycle.
- Data masking happens at enqueue. Bits above the target width are zeroed: paldef 12, tiledef 16, palmap 8, tilemap 6.
- States: IDLE, CLR_PAL, CLR_TILE, CLR_PMAP, CLR_TMAP.
- IDLE behaviour:
  - If blank and the FIFO is not empty, pop one entry per cycle and drive mem_* from it on the next edge.
  - Otherwise mem_we=0.
- Clear sequence:
  - clear_req in IDLE flushes the FIFO and clears cpu_err.
  - It then enters CLR_PAL with a counter at 0.
  - Each CLR_* state writes zero to addresses 0..N-1 at one per cycle, ignoring blank. N is 16, 1024, 300 and 300 respectively.
  - From the last address, move to the next state. After CLR_TMAP, go to IDLE.
- clear_req while busy is ignored.
- busy = (state != IDLE).
- Reset forces CLR_PAL with the counter at 0, an empty FIFO and cpu_err=0. An automatic clear therefore follows every reset.
- Reset asserted mid-clear restarts the clear from paldef address 0.
- FIFO pointers are log2(DEPTH)+1 bits. Full and empty come from the MSB/LSB compare, and wrap-around is free-running.

## Timing
- Reset values, on the edge after reset is sampled high:
  - mem_we=0, mem_sel=0, mem_addr=0, mem_data=0.
  - cpu_err=0, busy=1, cpu_ready=0.
- Clear duration: 16+1024+300+300 = 1640 consecutive mem_we cycles. busy falls on the edge after the last clear write.
  - Reset-started clear: first mem_we (paldef, 0) is on the first edge after reset deasserts.
  - clear_req-started clear: busy rises on the edge after clear_req, and the first mem_we appears one edge after that.
- Write latency: a write accepted at edge E is popped at edge E+1 if blank is high in that cycle. mem_we is valid in the cycle after edge E+1, so minimum latency is 2 cycles.
- Throughput: 1 commit per blank cycle. Commit order equals acceptance order.
- Blank falling stops pops that same cycle. A pop already registered still completes, so at most one mem_we cycle lands after blank falls.
- Simultaneous push and pop: both occur and occupancy is unchanged.
- Simultaneous clear_req and cpu_wr in IDLE: the write is accepted, then flushed by the clear.

## Test plan
- Reset deasserted: busy=1 for exactly 1640 cycles.
  - Writes occur at sel 0 addr 0..15, sel 1 addr 0..1023, sel 2 addr 0..299, sel 3 addr 0..299, all with data 0.
  - Then busy=0 and cpu_ready=1.
- blank=0, write sel2 addr 5 data 0xABCD, then raise blank 10 cycles later.
  - No mem_we before blank is high.
  - Then a single mem_we with sel2, addr5, data 0x00CD.
- blank=0, issue 6 back-to-back writes with DEPTH=4.
  - cpu_ready drops after 4 accepts.
  - Raise blank: 4 commits in order, cpu_ready rises, and the remaining 2 are accepted and committed.
- Write sel0 addr 16, then sel3 addr 300.
  - Both are accepted, with no mem_we.
  - cpu_err=1 and stays 1 until clear_req.
- Queue 3 writes with blank=0, then pulse clear_req.
  - The FIFO is flushed and none of the 3 writes reach the memory.
  - A 1640-cycle zeroing follows and cpu_err is 0.
- Assert reset for 1 cycle at clear cycle 500.
  - The clear restarts at paldef addr 0 and busy lasts a full 1640 cycles.

Source files
------------

// File: rtl/vram_ctrl.sv
// vram_ctrl: queues CPU writes to the tile-video memories, commits them only during
// blanking through one registered write port, and sequences a zeroing walk of every memory.
module vram_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blank,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_sel,
  input  logic [9:0]  cpu_addr,
  input  logic [15:0] cpu_data,
  output logic        cpu_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic        cpu_err,
  output logic        mem_we,
  output logic [1:0]  mem_sel,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_data
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, CLR_PAL, CLR_TILE, CLR_PMAP, CLR_TMAP} state_t;

  function automatic logic in_range(input logic [1:0] sel, input logic [9:0] addr);
    case (sel)
      2'd0:    in_range = (addr < 10'd16);
      2'd1:    in_range = 1'b1;
      default: in_range = (addr < 10'd300);
    endcase
  endfunction

  function automatic logic [15:0] mask_data(input logic [1:0] sel, input logic [15:0] data);
    case (sel)
      2'd0:    mask_data = {4'h0, data[11:0]};
      2'd1:    mask_data = data;
      2'd2:    mask_data = {8'h00, data[7:0]};
      default: mask_data = {10'h000, data[5:0]};
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  w_clr_sel;
  logic [PW:0] r_wptr, r_rptr;
  logic        r_err;
  logic [1:0]  r_fifo_sel  [DEPTH];
  logic [9:0]  r_fifo_addr [DEPTH];
  logic [15:0] r_fifo_data [DEPTH];
  logic        r_mem_we;
  logic [1:0]  r_mem_sel;
  logic [9:0]  r_mem_addr;
  logic [15:0] r_mem_data;

  logic w_full, w_empty, w_accept, w_in_range, w_clear, w_push, w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty    = (r_wptr == r_rptr);
  assign cpu_ready  = !w_full && (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign cpu_err    = r_err;
  assign w_accept   = cpu_wr && cpu_ready;
  assign w_in_range = in_range(cpu_sel, cpu_addr);
  assign w_clear    = (r_state == IDLE) && clear_req;
  assign w_push     = w_accept && w_in_range && !w_clear;
  assign w_pop      = (r_state == IDLE) && !w_clear && blank && !w_empty;

  assign mem_we   = r_mem_we;
  assign mem_sel  = r_mem_sel;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_sel   = 2'd0;
    case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_state_nxt = CLR_PAL;
          w_cnt_nxt   = 10'd0;
        end
      end
      CLR_PAL: begin
        w_clr_sel = 2'd0;
        if (r_cnt == 10'd15) begin
          w_state_nxt = CLR_TILE;
          w_cnt_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      CLR_TILE: begin
        w_clr_sel = 2'd1;
        if (r_cnt == 10'd1023) begin
          w_state_nxt = CLR_PMAP;
          w_cnt_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      CLR_PMAP: begin
        w_clr_sel = 2'd2;
        if (r_cnt == 10'd299) begin
          w_state_nxt = CLR_TMAP;
          w_cnt_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      CLR_TMAP: begin
        w_clr_sel = 2'd3;
        if (r_cnt == 10'd299) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 10'd0;
      end
    endcase
  end

  // Control state, FIFO pointers and the registered memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLR_PAL;
      r_cnt      <= 10'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err      <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_sel  <= 2'd0;
      r_mem_addr <= 10'd0;
      r_mem_data <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_accept && !w_in_range) r_err <= 1'b1;
      end
      if (r_state != IDLE) begin
        r_mem_we   <= 1'b1;
        r_mem_sel  <= w_clr_sel;
        r_mem_addr <= r_cnt;
        r_mem_data <= 16'd0;
      end else if (w_pop) begin
        r_mem_we   <= 1'b1;
        r_mem_sel  <= r_fifo_sel[r_rptr[PW-1:0]];
        r_mem_addr <= r_fifo_addr[r_rptr[PW-1:0]];
        r_mem_data <= r_fifo_data[r_rptr[PW-1:0]];
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  // FIFO storage holds data already masked to the target width.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_sel[r_wptr[PW-1:0]]  <= cpu_sel;
      r_fifo_addr[r_wptr[PW-1:0]] <= cpu_addr;
      r_fifo_data[r_wptr[PW-1:0]] <= mask_data(cpu_sel, cpu_data);
    end
  end

endmodule

// File: tb/tb_vram_ctrl.sv
// tb_vram_ctrl: directed bench with an expected-commit queue checked on every mem_we cycle.
module tb_vram_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_sel = 2'd0;
  logic [9:0]  cpu_addr = 10'd0;
  logic [15:0] cpu_data = 16'd0;
  logic        clear_req = 1'b0;
  logic        cpu_ready, busy, cpu_err, mem_we;
  logic [1:0]  mem_sel;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;

  typedef struct packed {
    logic        clr;
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic blank_prev = 1'b0;

  vram_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .blank(blank), .cpu_wr(cpu_wr), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .clear_req(clear_req), .busy(busy), .cpu_err(cpu_err), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [1:0] s, input logic [9:0] a);
    case (s)
      2'd0:    return a < 10'd16;
      2'd1:    return 1'b1;
      default: return a < 10'd300;
    endcase
  endfunction

  function automatic logic [15:0] masked(input logic [1:0] s, input logic [15:0] d);
    int w;
    logic [31:0] m;
    w = (s == 2'd0) ? 12 : (s == 2'd1) ? 16 : (s == 2'd2) ? 8 : 6;
    m = (32'h1 << w) - 32'h1;
    return d & m[15:0];
  endfunction

  task automatic push_clear();
    int  lim [4];
    wr_t e;
    lim = '{16, 1024, 300, 300};
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < lim[s]; a++) begin
        e.clr  = 1'b1;
        e.sel  = 2'(s);
        e.addr = 10'(a);
        e.data = 16'h0000;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] s, input logic [9:0] a, input logic [15:0] d,
                           output int waited);
    wr_t e;
    cpu_wr = 1'b1; cpu_sel = s; cpu_addr = a; cpu_data = d;
    waited = 0;
    while (!cpu_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!cpu_ready) begin
      chk("ready_timeout", 32'(cpu_ready), 32'd1);
    end else begin
      if (in_range(s, a)) begin
        e.clr = 1'b0; e.sel = s; e.addr = a; e.data = masked(s, d);
        exp_q.push_back(e);
      end
      tick();
    end
    cpu_wr = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) blank_prev <= blank;

  // Every committed write must be the next expected one; CPU writes must pop in blank.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: sel=%0d addr=%0d data=0x%0h, expected no write",
                 mem_sel, mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit", {4'h0, mem_sel, mem_addr, mem_data}, {4'h0, mon_e.sel, mon_e.addr, mon_e.data});
        if (!mon_e.clr) chk("commit_in_blank", 32'(blank_prev), 32'd1);
      end
    end
  end

  initial begin
    int w;
    int n;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);

    @(posedge clk);
    #1 reset = 1'b0;
    push_clear();
    count_busy(n);
    chk("reset_clear_busy_cycles", 32'(n), 32'd1640);
    chk("ready_after_clear", 32'(cpu_ready), 32'd1);
    tick();
    tick();
    chk("reset_clear_drained", 32'(exp_q.size()), 32'd0);

    // Single write held off until blank
    blank = 1'b0;
    cpu_write(2'd2, 10'd5, 16'hABCD, w);
    chk("single_accept_wait", 32'(w), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_write_unblanked", 32'(mem_we), 32'd0);
    end
    @(posedge clk);
    #1 blank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("single_we", 32'(mem_we), 32'd1);
    chk("single_sel", 32'(mem_sel), 32'd2);
    chk("single_addr", 32'(mem_addr), 32'd5);
    chk("single_data", 32'(mem_data), 32'h00CD);
    @(negedge clk);
    chk("single_only_once", 32'(mem_we), 32'd0);

    // Fill the FIFO with blank low, then drain
    tick();
    blank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_write(2'(i), 10'(10 + i), 16'hFFF0 + 16'(i), w);
      chk("fill_accept_wait", 32'(w), 32'd0);
    end
    chk("ready_low_when_full", 32'(cpu_ready), 32'd0);
    blank = 1'b1;
    cpu_write(2'd1, 10'd500, 16'h5A5A, w);
    chk("ready_after_first_pop", 32'(w), 32'd1);
    cpu_write(2'd3, 10'd299, 16'hFFFF, w);
    wait_drain("fill_drained");

    // Out-of-range writes are consumed and flagged
    chk("err_before_bad", 32'(cpu_err), 32'd0);
    cpu_write(2'd0, 10'd16, 16'h1111, w);
    chk("bad_pal_accepted", 32'(w), 32'd0);
    cpu_write(2'd3, 10'd300, 16'h2222, w);
    chk("bad_tmap_accepted", 32'(w), 32'd0);
    chk("err_set", 32'(cpu_err), 32'd1);
    cpu_write(2'd1, 10'h3FF, 16'h1234, w);
    @(negedge clk);
    chk("lat_not_yet", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("lat_we", 32'(mem_we), 32'd1);
    chk("lat_sel", 32'(mem_sel), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'h3FF);
    chk("lat_data", 32'(mem_data), 32'h1234);
    repeat (3) tick();
    chk("err_sticky", 32'(cpu_err), 32'd1);

    // Queued writes are flushed by clear_req, including one accepted alongside it
    blank = 1'b0;
    for (int i = 1; i <= 3; i++) cpu_write(2'd2, 10'(i), 16'h00A0 + 16'(i), w);
    cpu_wr = 1'b1; cpu_sel = 2'd0; cpu_addr = 10'd2; cpu_data = 16'h0007;
    clear_req = 1'b1;
    chk("ready_with_clear_req", 32'(cpu_ready), 32'd1);
    exp_q.delete();
    tick();
    cpu_wr = 1'b0;
    clear_req = 1'b0;
    blank = 1'b1;
    push_clear();
    @(negedge clk);
    chk("clr_busy_rise", 32'(busy), 32'd1);
    chk("clr_first_we_later", 32'(mem_we), 32'd0);
    chk("clr_err_cleared", 32'(cpu_err), 32'd0);
    count_busy(n);
    chk("clr_busy_cycles", 32'(n + 1), 32'd1640);
    repeat (3) tick();
    chk("clr_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-clear restarts the walk
    blank = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear();
    repeat (500) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    push_clear();
    count_busy(n);
    chk("restart_busy_cycles", 32'(n), 32'd1640);
    chk("restart_ready", 32'(cpu_ready), 32'd1);
    chk("restart_err", 32'(cpu_err), 32'd0);
    repeat (3) tick();
    chk("restart_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
